// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter with byte FIFO and CTS# flow control.
//                Define UART_TX_PARITY_EN for 8E1 framing with an even parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_HZ  = 12000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             cts,
    output logic             tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int               c_CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int               c_BW           = $clog2(c_CLKS_PER_BIT + 1);
    localparam logic [c_BW-1:0]  c_BAUD_LAST    = c_BW'(c_CLKS_PER_BIT - 1);
    localparam int               c_DEPTH        = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL         = (FIFO_AW + 1)'(c_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_cts_meta;
    logic               r_cts_s;
    logic [2:0]         r_state;
    logic [c_BW-1:0]    r_baud;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_baud_end;
    logic w_tx_next;

    assign data_ready = (r_count != c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = data_valid && data_ready;
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    // CTS is only consulted when a new frame could begin, never mid-frame.
    assign w_pop      = !w_empty && !r_cts_s &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

    assign tx         = r_tx;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || !w_empty;

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Synchroniser resets to "not clear to send" so nothing starts before cts is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cts_meta <= 1'b1;
            r_cts_s    <= 1'b1;
        end else begin
            r_cts_meta <= cts;
            r_cts_s    <= r_cts_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_tx <= w_tx_next;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) r_state <= S_START;
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_state   <= S_DATA;
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_state <= S_STOP;
                        r_baud  <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= w_pop ? S_START : S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                end
            endcase
            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_parity <= ^r_mem[r_rd_ptr];
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx at default baud.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 104;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       cts = 1'b0;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .cts        (cts),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Expected line levels in time order: start, d0..d7, [parity], stop.
    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic wait_start(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // Current negedge is the first sample of the start bit.
    task automatic sample_frame(output logic [NB-1:0] lvl, output logic [NB-1:0] stab);
        lvl  = '0;
        stab = '0;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < CPB; k++) begin
                if (!(b == 0 && k == 0)) @(negedge clk);
                if (k == 0) begin
                    lvl[b]  = tx;
                    stab[b] = 1'b1;
                end else if (tx !== lvl[b]) begin
                    stab[b] = 1'b0;
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cts   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx, busy, data_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL reset_state: got tx=%b busy=%b ready=%b count=%0d, expected 1 0 1 0",
                     tx, busy, data_ready, fifo_count);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [NB-1:0] lvl, stab;
        int n;
        push(8'h55);
        checks++;
        if (tx !== 1'b1 || fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL basic_accept: got tx=%b count=%0d, expected tx=1 count=1", tx, fifo_count);
        end
        wait_start(20, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL basic_latency: start seen %0d edges after accept, expected 2", n);
        end
        sample_frame(lvl, stab);
        checks++;
        if (lvl !== frame_of(8'h55) || stab !== '1) begin
            errors++;
            $display("FAIL basic_frame: got %b stable %b, expected %b", lvl, stab, frame_of(8'h55));
        end
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got tx=%b busy=%b, expected 1 0", tx, busy);
        end
    endtask

    task automatic test_cts_hold;
        logic [NB-1:0] lvl, stab;
        int n, lows;
        cts = 1'b1;
        repeat (3) @(negedge clk);
        push(8'hA3);
        lows = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL cts_hold: got %0d low samples count=%0d, expected 0 low count=1", lows, fifo_count);
        end
        cts = 1'b0;
        wait_start(20, n);
        checks++;
        if (n < 1 || n > 4) begin
            errors++;
            $display("FAIL cts_release_latency: got %0d clks, expected 1..4", n);
        end
        sample_frame(lvl, stab);
        checks++;
        if (lvl !== frame_of(8'hA3) || stab !== '1) begin
            errors++;
            $display("FAIL cts_frame: got %b stable %b, expected %b", lvl, stab, frame_of(8'hA3));
        end
    endtask

    task automatic test_fifo_full;
        logic [NB-1:0] lvl, stab;
        int n, lows, bad;
        cts = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            data_in    = 8'h20 + 8'(i);
            data_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (data_ready !== 1'b0 || fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL fifo_full: got ready=%b count=%0d, expected 0 16", data_ready, fifo_count);
        end
        data_in = 8'hEE;
        @(negedge clk);
        data_valid = 1'b0;
        checks++;
        if (fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL fifo_overflow: got count=%0d, expected 16", fifo_count);
        end
        cts = 1'b0;
        wait_start(20, n);
        checks++;
        if (n < 1 || n > 4) begin
            errors++;
            $display("FAIL full_release_latency: got %0d clks, expected 1..4", n);
        end
        bad = 0;
        for (int f = 0; f < 16; f++) begin
            if (f > 0) begin
                @(negedge clk);
                checks++;
                if (tx !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: frame %0d got tx=%b at start slot, expected 0", f, tx);
                end
            end
            sample_frame(lvl, stab);
            checks++;
            if (lvl !== frame_of(8'h20 + 8'(f)) || stab !== '1) begin
                errors++;
                $display("FAIL b2b_frame: frame %0d got %b stable %b, expected %b",
                         f, lvl, stab, frame_of(8'h20 + 8'(f)));
            end
        end
        lows = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || busy !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL overflow_dropped: got %0d low samples busy=%b count=%0d, expected 0 0 0",
                     lows, busy, fifo_count);
        end
    endtask

    task automatic test_midframe_cts;
        logic [NB-1:0] lvl, stab;
        int n, lows;
        data_in    = 8'h0F;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'hF0;
        @(negedge clk);
        data_valid = 1'b0;
        checks++;
        if (fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL push_pop_same_cycle: got count=%0d, expected 1", fifo_count);
        end
        wait_start(20, n);
        fork
            begin
                repeat (4 * CPB + 50) @(negedge clk);
                cts = 1'b1;
            end
        join_none
        sample_frame(lvl, stab);
        checks++;
        if (lvl !== frame_of(8'h0F) || stab !== '1) begin
            errors++;
            $display("FAIL midframe_frame: got %b stable %b, expected %b", lvl, stab, frame_of(8'h0F));
        end
        lows = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL midframe_hold: got %0d low samples count=%0d, expected 0 1", lows, fifo_count);
        end
        cts = 1'b0;
        wait_start(20, n);
        sample_frame(lvl, stab);
        checks++;
        if (lvl !== frame_of(8'hF0) || stab !== '1) begin
            errors++;
            $display("FAIL midframe_next: got %b stable %b, expected %b", lvl, stab, frame_of(8'hF0));
        end
    endtask

    task automatic test_reset_midframe;
        int n, lows;
        repeat (4) @(negedge clk);
        data_in    = 8'hC3;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h5A;
        @(negedge clk);
        data_valid = 1'b0;
        wait_start(20, n);
        repeat (6 * CPB + 50) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_bit5: got tx=%b, expected 0", tx);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tx, busy, data_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL async_reset: got tx=%b busy=%b ready=%b count=%0d, expected 1 0 1 0",
                     tx, busy, data_ready, fifo_count);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d active samples, expected 0", lows);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [NB-1:0] lvl, stab;
        int n;
        data_in    = 8'h07;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h03;
        @(negedge clk);
        data_valid = 1'b0;
        wait_start(20, n);
        sample_frame(lvl, stab);
        checks++;
        if (lvl !== {1'b1, 1'b1, 8'h07, 1'b0} || stab !== '1) begin
            errors++;
            $display("FAIL parity_07: got %b stable %b, expected %b", lvl, stab, {1'b1, 1'b1, 8'h07, 1'b0});
        end
        @(negedge clk);
        sample_frame(lvl, stab);
        checks++;
        if (lvl !== {1'b1, 1'b0, 8'h03, 1'b0} || stab !== '1) begin
            errors++;
            $display("FAIL parity_03: got %b stable %b, expected %b", lvl, stab, {1'b1, 1'b0, 8'h03, 1'b0});
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_cts_hold;
        test_fifo_full;
        test_midframe_cts;
        test_reset_midframe;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
